// File: rtl/input_arb_pkg.sv
// Shared button indices, state encodings and queue depth for input_owner_arbiter.
package input_arb_pkg;
  localparam int unsigned BTN_RIGHT  = 0;
  localparam int unsigned BTN_LEFT   = 1;
  localparam int unsigned BTN_DOWN   = 2;
  localparam int unsigned BTN_UP     = 3;
  localparam int unsigned BTN_SKIP   = 4;
  localparam int unsigned BTN_START1 = 5;
  localparam int unsigned BTN_START2 = 6;
  localparam int unsigned BTN_COIN   = 7;

  localparam int unsigned COIN_QMAX  = 3;

  typedef enum logic {IDLE, OWNED} owner_state_t;
  typedef enum logic [1:0] {C_IDLE, C_HIGH, C_LOW} coin_state_t;
endpackage

// File: rtl/input_owner_arbiter_if.sv
// Per-player bundle between the source-merging logic and the arbiter.
interface input_owner_arbiter_if #(
  parameter int unsigned NSRC = 3
);
  localparam int unsigned OW = (NSRC > 1) ? $clog2(NSRC) : 1;

  logic              tick;
  logic              osd_active;
  logic [NSRC-1:0]   src_valid;
  logic [8*NSRC-1:0] src_btn;
  logic [7:0]        btn_out;
  logic [OW-1:0]     owner;
  logic              owner_valid;
  logic              coin_overflow;

  modport master (
    output tick, osd_active, src_valid, src_btn,
    input  btn_out, owner, owner_valid, coin_overflow
  );

  modport slave (
    input  tick, osd_active, src_valid, src_btn,
    output btn_out, owner, owner_valid, coin_overflow
  );
endinterface

// File: rtl/coin_pulse_queue.sv
// Queues coin requests (depth COIN_QMAX) and replays each as a tick-timed high/low pulse.
module coin_pulse_queue
  import input_arb_pkg::*;
#(
  parameter int unsigned COIN_TICKS = 4,
  parameter int unsigned CNT_W      = 8
) (
  input  logic clk_sys,
  input  logic RESET,
  input  logic tick,
  input  logic osd_active,
  input  logic req,
  output logic coin_high,
  output logic overflow
);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(COIN_TICKS - 1);
  localparam logic [1:0]       QMAX     = 2'(COIN_QMAX);

  coin_state_t      state, state_nx;
  logic [1:0]       pending, pending_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic             deq, accept, ovf_nx;

  always_comb begin
    state_nx   = state;
    cnt_nx     = cnt;
    deq        = 1'b0;
    case (state)
      C_IDLE: if (pending != '0) begin
        state_nx = C_HIGH;
        cnt_nx   = '0;
        deq      = 1'b1;
      end
      C_HIGH: if (tick) begin
        if (cnt == CNT_LAST) begin
          state_nx = C_LOW;
          cnt_nx   = '0;
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end
      C_LOW: if (tick) begin
        if (cnt == CNT_LAST) begin
          state_nx = C_IDLE;
          cnt_nx   = '0;
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end
      default: state_nx = C_IDLE;
    endcase

    // A dequeue frees a slot in the same cycle, so a full queue still accepts then.
    accept     = req && !osd_active && ((pending != QMAX) || deq);
    ovf_nx     = req && !osd_active && (pending == QMAX) && !deq;
    pending_nx = pending;
    if (accept && !deq)      pending_nx = pending + 1'b1;
    else if (deq && !accept) pending_nx = pending - 1'b1;
  end

  always_ff @(posedge clk_sys or posedge RESET) begin
    if (RESET) begin
      state    <= C_IDLE;
      pending  <= '0;
      cnt      <= '0;
      overflow <= 1'b0;
    end else begin
      state    <= state_nx;
      pending  <= pending_nx;
      cnt      <= cnt_nx;
      overflow <= ovf_nx;
    end
  end

  assign coin_high = (state == C_HIGH);
endmodule

// File: rtl/input_owner_arbiter.sv
// Grants one player input port to a single source with idle takeover and shaped coin pulses.
// Optional INPUT_ARB_ONEDIR_EN: last-pressed-wins filter on the four direction bits.
module input_owner_arbiter
  import input_arb_pkg::*;
#(
  parameter int unsigned NSRC       = 3,
  parameter int unsigned IDLE_TICKS = 60,
  parameter int unsigned COIN_TICKS = 4,
  parameter int unsigned CNT_W      = 8
) (
  input logic                  clk_sys,
  input logic                  RESET,
  input_owner_arbiter_if.slave bus
);
  localparam int unsigned      OW       = (NSRC > 1) ? $clog2(NSRC) : 1;
  localparam logic [CNT_W-1:0] IDLE_MAX = CNT_W'(IDLE_TICKS);

  function automatic logic [OW-1:0] lowest_idx(input logic [NSRC-1:0] v);
    logic found;
    found      = 1'b0;
    lowest_idx = '0;
    for (int unsigned i = 0; i < NSRC; i++) begin
      if (v[i] && !found) begin
        lowest_idx = OW'(i);
        found      = 1'b1;
      end
    end
  endfunction

  logic [NSRC-1:0]  s1_valid;
  logic [7:0]       s1_btn [NSRC];
  logic [NSRC-1:0]  act, others;
  logic [OW-1:0]    first_act, first_other;
  owner_state_t     state, state_nx;
  logic [OW-1:0]    owner, owner_nx;
  logic [CNT_W-1:0] idle_cnt, idle_nx;
  logic             coin_prev, coin_prev_nx, coin_req;
  logic [6:0]       btn_q, btn_nx;
  logic             own_valid, own_act, own_coin;
  logic             coin_high, coin_ovf;

  always_ff @(posedge clk_sys or posedge RESET) begin
    if (RESET) begin
      s1_valid <= '0;
      for (int unsigned i = 0; i < NSRC; i++) s1_btn[i] <= '0;
    end else begin
      s1_valid <= bus.src_valid;
      for (int unsigned i = 0; i < NSRC; i++) s1_btn[i] <= bus.src_btn[8*i +: 8];
    end
  end

  always_comb begin
    act = '0;
    for (int unsigned i = 0; i < NSRC; i++) act[i] = s1_valid[i] && (s1_btn[i] != '0);
    others        = act;
    others[owner] = 1'b0;
  end

  assign first_act   = lowest_idx(act);
  assign first_other = lowest_idx(others);
  assign own_valid   = s1_valid[owner];
  assign own_act     = act[owner];
  assign own_coin    = s1_btn[owner][BTN_COIN];

  always_comb begin
    state_nx     = state;
    owner_nx     = owner;
    idle_nx      = idle_cnt;
    coin_prev_nx = coin_prev;
    coin_req     = 1'b0;
    btn_nx       = '0;
    if (!bus.osd_active) begin
      case (state)
        IDLE: if (act != '0) begin
          state_nx     = OWNED;
          owner_nx     = first_act;
          idle_nx      = '0;
          coin_prev_nx = s1_btn[first_act][BTN_COIN];
        end
        OWNED: if (!own_valid) begin
          state_nx = IDLE;
          idle_nx  = '0;
        end else begin
          btn_nx       = s1_btn[owner][BTN_START2:0];
          coin_req     = own_coin && !coin_prev;
          coin_prev_nx = own_coin;
          if (own_act) begin
            idle_nx = '0;
          end else if ((idle_cnt == IDLE_MAX) && (others != '0)) begin
            owner_nx     = first_other;
            idle_nx      = '0;
            coin_prev_nx = s1_btn[first_other][BTN_COIN];
          end else if (bus.tick && (idle_cnt != IDLE_MAX)) begin
            idle_nx = idle_cnt + 1'b1;
          end
        end
        default: state_nx = IDLE;
      endcase
    end else if (state == OWNED) begin
      // Track the coin bit while the OSD is open so presses made there are swallowed.
      coin_prev_nx = own_coin;
    end
  end

  always_ff @(posedge clk_sys or posedge RESET) begin
    if (RESET) begin
      state     <= IDLE;
      owner     <= '0;
      idle_cnt  <= '0;
      coin_prev <= 1'b0;
      btn_q     <= '0;
    end else begin
      state     <= state_nx;
      owner     <= owner_nx;
      idle_cnt  <= idle_nx;
      coin_prev <= coin_prev_nx;
      btn_q     <= btn_nx;
    end
  end

  coin_pulse_queue #(
    .COIN_TICKS (COIN_TICKS),
    .CNT_W      (CNT_W)
  ) u_coin (
    .clk_sys    (clk_sys),
    .RESET      (RESET),
    .tick       (bus.tick),
    .osd_active (bus.osd_active),
    .req        (coin_req),
    .coin_high  (coin_high),
    .overflow   (coin_ovf)
  );

`ifdef INPUT_ARB_ONEDIR_EN
  logic       own_chg, own_chg_q;
  logic [3:0] dir_prev, dir_mask, dir_mask_nx, dir_rise, dir_q;

  assign own_chg = (state_nx != state) || (owner_nx != owner);

  always_comb begin
    dir_rise    = btn_q[BTN_UP:BTN_RIGHT] & ~dir_prev;
    dir_mask_nx = dir_mask;
    if (own_chg_q)            dir_mask_nx = '0;
    else if (dir_rise != '0)  dir_mask_nx = dir_rise & (~dir_rise + 4'd1);
  end

  always_ff @(posedge clk_sys or posedge RESET) begin
    if (RESET) begin
      own_chg_q <= 1'b0;
      dir_prev  <= '0;
      dir_mask  <= '0;
      dir_q     <= '0;
    end else begin
      own_chg_q <= own_chg;
      dir_prev  <= btn_q[BTN_UP:BTN_RIGHT];
      dir_mask  <= dir_mask_nx;
      dir_q     <= btn_q[BTN_UP:BTN_RIGHT] & dir_mask_nx;
    end
  end

  assign bus.btn_out = {coin_high, btn_q[BTN_START2:BTN_SKIP], dir_q};
`else
  assign bus.btn_out = {coin_high, btn_q};
`endif

  assign bus.owner         = owner;
  assign bus.owner_valid   = (state == OWNED);
  assign bus.coin_overflow = coin_ovf;
endmodule

// File: tb/tb_input_owner_arbiter.sv
// Scoreboard bench for input_owner_arbiter (NSRC=3, IDLE_TICKS=4, COIN_TICKS=2).
module tb_input_owner_arbiter;
  localparam int SIG_BTN = 0, SIG_OWNER = 1, SIG_OWNV = 2, SIG_OVF = 3, SIG_PULSES = 4, SIG_OVFS = 5;

  typedef struct {
    int unsigned due;
    int          sig;
    logic [31:0] val;
    string       tag;
  } sb_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        auto_tick = 1'b0;
  logic        coin_seen = 1'b0;
  int unsigned cyc = 0;
  int unsigned n_checks = 0, n_errors = 0;
  int unsigned pulse_cnt = 0, ovf_cnt = 0, hi_ticks = 0;
  int unsigned base_p, base_o;
  sb_t         sb_q[$];

  input_owner_arbiter_if #(.NSRC(3)) bus ();

  input_owner_arbiter #(
    .NSRC       (3),
    .IDLE_TICKS (4),
    .COIN_TICKS (2),
    .CNT_W      (8)
  ) dut (
    .clk_sys (clk),
    .RESET   (rst),
    .bus     (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", tag, got, want, cyc);
    end
  endtask

  function automatic logic [31:0] observe(input int sig);
    case (sig)
      SIG_BTN:    return 32'(bus.btn_out);
      SIG_OWNER:  return 32'(bus.owner);
      SIG_OWNV:   return 32'(bus.owner_valid);
      SIG_OVF:    return 32'(bus.coin_overflow);
      SIG_PULSES: return pulse_cnt;
      SIG_OVFS:   return ovf_cnt;
      default:    return '1;
    endcase
  endfunction

  task automatic sb_push(input int unsigned dly, input int sig, input logic [31:0] val, input string tag);
    sb_q.push_back('{due: cyc + dly, sig: sig, val: val, tag: tag});
  endtask

  task automatic step(input int unsigned n);
    repeat (n) begin
      @(posedge clk);
      #1;
      bus.tick = auto_tick && (cyc % 8 == 0);
    end
  endtask

  task automatic set_btn(input int unsigned i, input logic [7:0] v);
    bus.src_btn[8*i +: 8] = v;
  endtask

  // Scoreboard pop plus a coin-pulse monitor that measures high width in ticks.
  always @(negedge clk) begin
    for (int i = sb_q.size() - 1; i >= 0; i--) begin
      if (sb_q[i].due == cyc) begin
        check_eq(sb_q[i].tag, observe(sb_q[i].sig), sb_q[i].val);
        sb_q.delete(i);
      end
    end
    if (rst) begin
      coin_seen = 1'b0;
      hi_ticks  = 0;
    end else begin
      if (bus.coin_overflow) ovf_cnt++;
      if (bus.btn_out[7] && !coin_seen) pulse_cnt++;
      if (!bus.btn_out[7] && coin_seen) begin
        check_eq("coin_high_ticks", hi_ticks, 2);
        hi_ticks = 0;
      end
      if (bus.btn_out[7] && bus.tick) hi_ticks++;
      coin_seen = bus.btn_out[7];
    end
  end

  initial begin
    rst            = 1'b1;
    bus.tick       = 1'b0;
    bus.osd_active = 1'b0;
    bus.src_valid  = '0;
    bus.src_btn    = '0;
    step(2);
    sb_push(0, SIG_BTN, 0, "reset_btn");
    sb_push(0, SIG_OWNV, 0, "reset_owner_valid");
    sb_push(0, SIG_OWNER, 0, "reset_owner");
    sb_push(0, SIG_OVF, 0, "reset_overflow");
    step(1);
    rst           = 1'b0;
    bus.src_valid = 3'b111;
    step(2);

    // Grant from IDLE
    set_btn(1, 8'h08);
    sb_push(1, SIG_OWNV, 0, "grant_not_early");
    sb_push(2, SIG_OWNER, 1, "grant_owner");
    sb_push(2, SIG_OWNV, 1, "grant_valid");
    sb_push(2, SIG_BTN, 0, "grant_btn_latency");
    sb_push(3, SIG_BTN, 8'h08, "grant_btn");
    step(4);

    // Idle takeover after IDLE_TICKS
    set_btn(1, 8'h00);
    set_btn(2, 8'h01);
    step(3);
    for (int k = 0; k < 3; k++) begin
      bus.tick = 1'b1;
      step(4);
    end
    sb_push(1, SIG_OWNER, 1, "takeover_3_ticks");
    bus.tick = 1'b1;
    sb_push(1, SIG_OWNER, 1, "takeover_boundary");
    sb_push(2, SIG_OWNER, 2, "takeover_owner");
    sb_push(3, SIG_BTN, 8'h01, "takeover_btn");
    step(4);

    // Owner invalid -> IDLE
    bus.src_valid[2] = 1'b0;
    set_btn(2, 8'h00);
    sb_push(1, SIG_OWNV, 1, "drop_not_early");
    sb_push(2, SIG_OWNV, 0, "drop_idle");
    sb_push(2, SIG_BTN, 0, "drop_btn");
    step(3);
    bus.src_valid[2] = 1'b1;
    step(2);

    // Simultaneous requests: lowest index wins
    set_btn(0, 8'h04);
    set_btn(2, 8'h02);
    sb_push(2, SIG_OWNER, 0, "prio_owner");
    sb_push(2, SIG_OWNV, 1, "prio_valid");
    sb_push(3, SIG_BTN, 8'h04, "prio_btn");
    step(4);

    // Coin burst: five edges before any tick -> four pulses, one overflow
    base_p = pulse_cnt;
    base_o = ovf_cnt;
    for (int k = 0; k < 5; k++) begin
      set_btn(0, 8'h84);
      step(1);
      set_btn(0, 8'h04);
      step(1);
    end
    auto_tick = 1'b1;
    step(200);
    sb_push(0, SIG_PULSES, base_p + 4, "coin_pulse_count");
    sb_push(0, SIG_OVFS, base_o + 1, "coin_overflow_count");
    step(1);

    // OSD masks buttons, swallows coin edges, freezes ownership
    bus.osd_active = 1'b1;
    set_btn(0, 8'h28);
    set_btn(2, 8'h01);
    base_p = pulse_cnt;
    sb_push(2, SIG_BTN, 0, "osd_btn_masked");
    step(3);
    set_btn(0, 8'hA8);
    step(2);
    set_btn(0, 8'h28);
    step(40);
    sb_push(0, SIG_PULSES, base_p, "osd_no_coin");
    sb_push(0, SIG_OWNER, 0, "osd_owner_frozen");
    bus.osd_active = 1'b0;
    sb_push(2, SIG_BTN, 8'h28, "osd_close_btn");
    sb_push(2, SIG_OWNER, 0, "osd_close_owner");
    step(4);

    // Owner loss mid-pulse: pulse still completes
    set_btn(2, 8'h00);
    base_p = pulse_cnt;
    set_btn(0, 8'hA8);
    step(3);
    sb_push(0, SIG_BTN, 8'hA8, "pulse_start");
    bus.src_valid[0] = 1'b0;
    sb_push(2, SIG_OWNV, 0, "midpulse_owner_valid");
    sb_push(2, SIG_BTN, 8'h80, "midpulse_btn");
    step(40);
    sb_push(0, SIG_PULSES, base_p + 1, "midpulse_completed");
    step(1);

    // RESET mid-pulse clears outputs without a clock edge
    bus.src_valid[0] = 1'b1;
    set_btn(0, 8'h00);
    set_btn(1, 8'h01);
    step(4);
    set_btn(1, 8'h81);
    step(3);
    sb_push(0, SIG_BTN, 8'h81, "pre_reset_pulse");
    @(negedge clk);
    #1;
    rst = 1'b1;
    #1;
    check_eq("async_reset_btn", 32'(bus.btn_out), 0);
    check_eq("async_reset_owner_valid", 32'(bus.owner_valid), 0);
    check_eq("async_reset_owner", 32'(bus.owner), 0);
    check_eq("async_reset_overflow", 32'(bus.coin_overflow), 0);
    step(2);
    rst = 1'b0;
    step(2);
    check_eq("scoreboard_drain", sb_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
